// File: rtl/convenc_frm.sv
// Frame-aware rate-1/N convolutional encoder with K-1 zero-tail flush and start-of-frame clearing.
// Optional rate 2/3 / 3/4 puncturing (N=2 only) is compiled in with CONVENC_PUNCT_EN.
module convenc_frm #(
  parameter int unsigned K = 7,
  parameter int unsigned N = 2,
  parameter logic [N*K-1:0] G = {7'o133, 7'o171}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dv_in,
  input  logic         din,
  input  logic         sof_in,
  input  logic         eof_in,
  input  logic [1:0]   punct_mode,
  output logic         ready_out,
  output logic         dv_out,
  output logic [N-1:0] dout,
  output logic [N-1:0] dout_mask,
  output logic         eof_out
);

  localparam int unsigned CntW = $clog2(K);

  typedef enum logic {StStream, StTail} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [K-2:0]    sr_q, sr_d, sr_w;
  logic            accept, in_tail, fire, sof_acc, last_tail, b;
  logic [K-1:0]    win;
  logic [N-1:0]    enc_w, mask_w;

  assign ready_out = (state_q == StStream);
  assign accept    = dv_in & ready_out;
  assign in_tail   = (state_q == StTail);
  assign fire      = accept | in_tail;
  assign sof_acc   = accept & sof_in;
  assign last_tail = in_tail & (cnt_q == CntW'(1));
  assign b         = accept & din;
  // A start-of-frame bit sees an all-zero history regardless of what came before.
  assign sr_w      = sof_acc ? '0 : sr_q;
  assign win       = {b, sr_w};

  always_comb begin
    enc_w = '0;
    for (int j = 0; j < N; j++) begin
      enc_w[j] = ^(win & G[j*K +: K]);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    unique case (state_q)
      StStream: begin
        if (accept && eof_in) begin
          state_d = StTail;
          cnt_d   = CntW'(K - 1);
        end
      end
      StTail: begin
        cnt_d = cnt_q - CntW'(1);
        if (last_tail) state_d = StStream;
      end
    endcase
    if (fire) sr_d = last_tail ? '0 : {b, sr_w[K-2:1]};
  end

`ifdef CONVENC_PUNCT_EN
  localparam bit PunctOn = (N == 2);

  logic [1:0] phase_q, phase_d, mode_q, mode_d;
  logic [1:0] md, ph, ph_nxt, pm;

  always_comb begin
    md      = sof_acc ? punct_mode : mode_q;
    ph      = sof_acc ? 2'd0 : phase_q;
    pm      = 2'b11;
    ph_nxt  = 2'd0;
    mode_d  = md;
    phase_d = phase_q;
    unique case (md)
      2'd1: begin
        pm     = (ph == 2'd0) ? 2'b11 : 2'b01;
        ph_nxt = (ph == 2'd0) ? 2'd1 : 2'd0;
      end
      2'd2: begin
        unique case (ph)
          2'd0:    begin pm = 2'b11; ph_nxt = 2'd1; end
          2'd1:    begin pm = 2'b10; ph_nxt = 2'd2; end
          default: begin pm = 2'b01; ph_nxt = 2'd0; end
        endcase
      end
      default: begin
        pm     = 2'b11;
        ph_nxt = 2'd0;
      end
    endcase
    if (fire) phase_d = last_tail ? 2'd0 : ph_nxt;
    mask_w = '1;
    if (PunctOn) mask_w[1:0] = pm;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= 2'd0;
      mode_q  <= 2'd0;
    end else begin
      phase_q <= phase_d;
      mode_q  <= mode_d;
    end
  end
`else
  logic unused_punct;
  assign unused_punct = ^punct_mode;
  assign mask_w       = '1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StStream;
      cnt_q     <= '0;
      sr_q      <= '0;
      dv_out    <= 1'b0;
      dout      <= '0;
      dout_mask <= '0;
      eof_out   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      dv_out    <= fire;
      dout      <= fire ? enc_w : '0;
      dout_mask <= fire ? mask_w : '0;
      eof_out   <= last_tail;
    end
  end

endmodule

// File: tb/tb_convenc_frm.sv
// Scoreboard bench for convenc_frm (defaults K=7, N=2, G={133,171} octal).
module tb_convenc_frm;

  localparam int K = 7;
  localparam int N = 2;
  localparam logic [N*K-1:0] G = {7'o133, 7'o171};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dv_in = 1'b0, din = 1'b0, sof_in = 1'b0, eof_in = 1'b0;
  logic [1:0] punct_mode = 2'd0;
  logic ready_out, dv_out, eof_out;
  logic [N-1:0] dout, dout_mask;

  always #5 clk = ~clk;

  convenc_frm dut (
    .clk        (clk),
    .rst        (rst),
    .dv_in      (dv_in),
    .din        (din),
    .sof_in     (sof_in),
    .eof_in     (eof_in),
    .punct_mode (punct_mode),
    .ready_out  (ready_out),
    .dv_out     (dv_out),
    .dout       (dout),
    .dout_mask  (dout_mask),
    .eof_out    (eof_out)
  );

  typedef struct packed {
    logic [N-1:0] d;
    logic [N-1:0] m;
    logic         e;
  } exp_t;

  exp_t q[$];
  int n_chk = 0, n_fail = 0;
  int m_tail = 0;
  logic [K-2:0] m_sr = '0;
  logic [1:0] m_phase = 2'd0, m_mode = 2'd0;
  logic [N-1:0] cap_d[200];
  logic [N-1:0] cap_m[200];
  int ncap = 0, nlow = 0;
  logic [N-1:0] last_dout;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] enc(input logic [K-1:0] w);
    logic [N-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      for (int i = 0; i < K; i++)
        r[j] = r[j] ^ (w[i] & G[j*K+i]);
    return r;
  endfunction

  function automatic logic [N-1:0] mask_of(input logic sof);
    logic [N-1:0] m;
    m = '1;
`ifdef CONVENC_PUNCT_EN
    if (sof) begin
      m_mode  = punct_mode;
      m_phase = 2'd0;
    end
    if (m_mode == 2'd1) begin
      m = (m_phase == 2'd0) ? 2'b11 : 2'b01;
      m_phase = (m_phase == 2'd0) ? 2'd1 : 2'd0;
    end else if (m_mode == 2'd2) begin
      m = (m_phase == 2'd0) ? 2'b11 : (m_phase == 2'd1) ? 2'b10 : 2'b01;
      m_phase = (m_phase == 2'd2) ? 2'd0 : m_phase + 2'd1;
    end
`else
    if (sof) m = '1;
`endif
    return m;
  endfunction

  // One clock: drive before the edge, update model, check after the edge.
  task automatic step(input logic v, input logic d, input logic s, input logic e);
    logic [K-1:0] w;
    logic [K-2:0] srw;
    logic pushed, last;
    exp_t x;
    @(negedge clk);
    dv_in = v; din = d; sof_in = s; eof_in = e;
    check("ready", ready_out, m_tail == 0);
    pushed = 1'b0;
    if (m_tail == 0) begin
      if (v) begin
        srw = s ? '0 : m_sr;
        w = {d, srw};
        x.d = enc(w); x.m = mask_of(s); x.e = 1'b0;
        q.push_back(x);
        m_sr = {d, srw[K-2:1]};
        if (e) m_tail = K - 1;
        pushed = 1'b1;
      end
    end else begin
      last = (m_tail == 1);
      w = {1'b0, m_sr};
      x.d = enc(w); x.m = mask_of(1'b0); x.e = last;
      q.push_back(x);
      m_sr = last ? '0 : {1'b0, m_sr[K-2:1]};
      if (last) m_phase = 2'd0;
      m_tail--;
      pushed = 1'b1;
    end
    @(posedge clk);
    #1;
    check("dv_out", dv_out, pushed);
    if (!ready_out) nlow++;
    if (!dv_out) begin
      check("mask_idle", dout_mask, 0);
      check("eof_idle", eof_out, 0);
    end else if (q.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      x = q.pop_front();
      check("dout", dout, x.d);
      check("mask", dout_mask, x.m);
      check("eof_out", eof_out, x.e);
      last_dout = dout;
      if (ncap < 200) begin
        cap_d[ncap] = dout;
        cap_m[ncap] = dout_mask;
      end
      ncap++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; dv_in = 1'b0; sof_in = 1'b0; eof_in = 1'b0;
    @(posedge clk);
    #1;
    check("rst_dv", dv_out, 0);
    check("rst_dout", dout, 0);
    check("rst_mask", dout_mask, 0);
    check("rst_eof", eof_out, 0);
    check("rst_ready", ready_out, 1);
    q.delete();
    m_tail = 0; m_sr = '0; m_phase = 2'd0; m_mode = 2'd0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic impulse_frame();
    ncap = 0; nlow = 0;
    step(1'b1, 1'b1, 1'b1, 1'b1);
    idle(8);
  endtask

  initial begin
    logic [119:0] pat;
    logic [6:0] s0, s1;
    logic [13:0] ms;
    logic bit_v;

    do_reset();

    // Impulse with defaults
    impulse_frame();
    check("imp_words", ncap, 7);
    for (int i = 0; i < 7; i++) begin
      s0[6-i] = cap_d[i][0];
      s1[6-i] = cap_d[i][1];
    end
    check("imp_d0", s0, 7'b1111001);
    check("imp_d1", s1, 7'b1011011);
    check("imp_rdy_low", nlow, 6);

    // 120-bit frame, then an unframed bit that must start from sr=0
    pat = 120'hFFF0CCAA000F3355E3ECDF8A1C1340;
    ncap = 0;
    for (int i = 0; i < 120; i++)
      step(1'b1, pat[119-i], i == 0, i == 119);
    idle(7);
    check("frm_words", ncap, 126);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("post_flush", last_dout, 2'b11);

    // Back-pressure: dv_in held high across eof and the whole tail
    for (int i = 0; i < 10; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    check("bp_resume", last_dout, 2'b11);
    idle(2);

    // Mid-frame sof after random history
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 50; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      bit_v = (k == 0);
      step(1'b1, bit_v, 1'b1, 1'b0);
      check("midsof", last_dout, bit_v ? 2'b11 : 2'b00);
    end
    for (int i = 0; i < 5; i++) step(1'b1, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    idle(8);

    // Reset on the 3rd tail cycle
    for (int i = 0; i < 8; i++) step(1'b1, 1'($urandom_range(0, 1)), i == 0, i == 7);
    idle(2);
    do_reset();
    idle(8);
    impulse_frame();
    check("rst_reimp", ncap, 7);

`ifdef CONVENC_PUNCT_EN
    punct_mode = 2'd2;
    impulse_frame();
    for (int i = 0; i < 7; i++) ms[13-2*i -: 2] = cap_m[i];
    check("punct_m2", ms, 14'b11_10_01_11_10_01_11);
    punct_mode = 2'd1;
    impulse_frame();
    for (int i = 0; i < 7; i++) ms[13-2*i -: 2] = cap_m[i];
    check("punct_m1", ms, 14'b11_01_11_01_11_01_11);
`else
    ms = '0;
    punct_mode = 2'd2;
    impulse_frame();
    for (int i = 0; i < 7; i++) ms[13-2*i -: 2] = cap_m[i];
    check("nopunct_mask", ms, 14'h3FFF);
`endif

    check("sb_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/convenc_frm.md
# convenc_frm

Parametrised, frame-aware convolutional encoder, rate 1/N, constraint length K, with arbitrary generator polynomials. It is the next generation of the fixed K=7, rate-1/2 encoder and sits between the bit source and the modulator/interleaver. It adds start-of-frame state clearing and automatic K-1 zero-tail insertion with upstream back-pressure. Optional puncturing to rate 2/3 or 3/4 is compiled in with a macro.

## Interface
- K, default 7: constraint length, 3..9.
- N, default 2: output bits per input bit, 2..4.
- G, default {7'o133, 7'o171}: N packed K-bit polynomials. G[j*K +: K] drives dout[j]. Bit K-1 taps the current input bit.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- dv_in  in  1  input bit valid.
- din  in  1  input bit.
- sof_in  in  1  first bit of frame; qualified by dv_in.
- eof_in  in  1  last data bit of frame; qualified by dv_in.
- punct_mode  in  2  0 none, 1 rate 2/3, 2 rate 3/4, 3 treated as 0. Only used with the macro.
- ready_out  out  1  high when a bit can be accepted; low during tail.
- dv_out  out  1  output word valid.
- dout  out  N  encoded bits.
- dout_mask  out  N  1 = bit kept, 0 = punctured.
- eof_out  out  1  marks the last output word of a frame (last tail word).

## Operation
- Shift register sr[K-2:0], with sr[K-2] the most recent past bit.
- Window w = {b, sr}, where b is din or 0 during tail.
- dout[j] = XOR-reduce(w & G_j). After each use: sr <= {b, sr[K-2:1]}.
- Accepted bit: dv_in & ready_out. dv_in while ready_out=0 is ignored: no output, no state change.
- sof_in on an accepted bit: sr is treated as all zeros for that bit, then updates normally.
- Without sof_in, bits encode continuously from the current sr (stream mode, same as the old encoder).
- State machine:
  - STREAM: accepts bits. Accepted bit with eof_in -> TAIL, tail counter = K-1. sof_in and eof_in together is a legal 1-bit frame.
  - TAIL: ready_out=0. Each cycle encodes b=0, emits one word, decrements the counter. The last tail word has eof_out=1, then -> STREAM with sr=0.
- Width rules: dout is N bits, the tail counter is clog2(K) bits, and the puncture phase counter is 2 bits.

## Timing
- Reset values: dv_out=0, dout=0, dout_mask=0, eof_out=0, ready_out=1, sr=0, state STREAM, puncture phase 0.
- Latency: one cycle. A bit accepted on edge t gives dv_out/dout at edge t+1.
- Throughput: one bit per clock in STREAM.
- Tail words occupy K-1 consecutive cycles, starting the cycle after the eof word.
- ready_out falls on the edge that registers the eof bit's output and rises on the edge that registers the last tail word.
- dout_mask equals all ones whenever dv_out=1 and puncturing is inactive. It is 0 whenever dv_out=0.
- rst mid-frame or mid-tail: abort. Outputs return to reset values, no eof_out is emitted, and the tail counter clears.

## Configuration
- CONVENC_PUNCT_EN defined, N=2: a phase counter advances on each emitted word. It resets to 0 on rst, on an accepted sof_in bit, and after the last tail word. punct_mode is sampled on the sof bit (or held from reset).
  - Mode 1, masks {dout[1],dout[0]} by phase: 11, 01, repeat.
  - Mode 2: 11, 10, 01, repeat.
  - Tail words are punctured too.
- CONVENC_PUNCT_EN defined with N≠2, or not defined: no phase counter, punct_mode ignored, dout_mask all ones when dv_out=1.

## Test plan
- Impulse, defaults: din=1 with sof_in=1 and eof_in=1, then idle → 7 words. dout[0] sequence 1,1,1,1,0,0,1; dout[1] sequence 1,0,1,1,0,1,1. eof_out only on the 7th word. ready_out low for 6 cycles.
- 120-bit frame (pattern FFF0CCAA000F335 5E3ECDF8A1C1340 hex, MSB first) with sof_in/eof_in → 126 words. The first 120 match the unframed rate-1/2 golden model started from sr=0. The last 6 words are the flush, ending in sr=0.
- Back-pressure: hold dv_in=1 continuously across eof → bits offered during the 6 tail cycles produce no output. The bit offered when ready_out returns is encoded from sr=0.
- Mid-frame sof: stream 50 random bits, then a bit with sof_in → that word equals the single-bit impulse response's first word for din. Prior sr history has no effect.
- Reset mid-tail: assert rst on the 3rd tail cycle → next cycle dv_out=0, eof_out never asserted, ready_out=1. The next sof frame encodes correctly.
- With CONVENC_PUNCT_EN, punct_mode=2: impulse frame → masks 11,10,01,11,10,01,11 on the 7 words. punct_mode=1 gives 11,01,11,01,11,01,11.
